// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, MEM-stage and shared memory port signals of the memory arbiter.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        dm_read;
    logic        dm_write;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_ready, mem_rdata,
        output if_rdata, if_stall, dm_rdata, dm_stall, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_ready, mem_rdata,
        input  if_rdata, if_stall, dm_rdata, dm_stall, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and the MEM stage, data first.
module mem_arbiter (
    input logic           clk,
    input logic           rst,
    mem_arbiter_if.master bus
);
    typedef enum logic [2:0] {IDLE, IBUSY, DBUSY, IDONE, DDONE} state_t;

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic        dm_any;

    assign dm_any = bus.dm_read | bus.dm_write;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        case (state_q)
            IDLE: begin
                if (dm_any) begin
                    state_d     = DBUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.dm_write;
                    mem_addr_d  = bus.dm_addr;
                    mem_wdata_d = bus.dm_wdata;
                end else if (bus.if_req) begin
                    state_d    = IBUSY;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = bus.if_addr;
                end
            end
            IBUSY: begin
                if (bus.mem_ready) begin
                    state_d    = IDONE;
                    mem_req_d  = 1'b0;
                    if_rdata_d = bus.mem_rdata;
                end
            end
            DBUSY: begin
                if (bus.mem_ready) begin
                    state_d    = DDONE;
                    mem_req_d  = 1'b0;
                    dm_rdata_d = mem_we_q ? dm_rdata_q : bus.mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    // A fetch is released only when the completed word belongs to the address now requested.
    assign bus.if_stall  = bus.if_req & ~(state_q == IDONE && bus.if_addr == mem_addr_q);
    assign bus.dm_stall  = dm_any & (state_q != DDONE);
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, directed corner sequences and random traffic against a transaction-level model.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter_if bus ();
    mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic        rst, if_req;
        logic [31:0] if_addr;
        logic        dm_read, dm_write;
        logic [31:0] dm_addr, dm_wdata;
        logic        ready;
        logic [31:0] rdata;
        logic        e_req, e_we;
        logic [31:0] e_addr, e_wdata;
        logic        e_dst, e_ist;
        logic [31:0] e_drd;
    } vec_t;

    // Transaction-level reference: one outstanding access, plus a one-cycle completion marker.
    logic        m_busy, m_data, m_done_i, m_done_d, m_req, m_we;
    logic [31:0] m_addr, m_wdata, m_ird, m_drd;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 0; m_data <= 0; m_done_i <= 0; m_done_d <= 0; m_req <= 0; m_we <= 0;
            m_addr <= 0; m_wdata <= 0; m_ird <= 0; m_drd <= 0;
        end else if (m_done_i || m_done_d) begin
            m_done_i <= 0;
            m_done_d <= 0;
        end else if (m_busy) begin
            if (bus.mem_ready) begin
                m_busy <= 0;
                m_req  <= 0;
                if (m_data) begin
                    m_done_d <= 1;
                    if (!m_we) m_drd <= bus.mem_rdata;
                end else begin
                    m_done_i <= 1;
                    m_ird    <= bus.mem_rdata;
                end
            end
        end else if (bus.dm_read || bus.dm_write) begin
            m_busy <= 1; m_data <= 1; m_req <= 1; m_we <= bus.dm_write;
            m_addr <= bus.dm_addr; m_wdata <= bus.dm_wdata;
        end else if (bus.if_req) begin
            m_busy <= 1; m_data <= 0; m_req <= 1; m_we <= 0;
            m_addr <= bus.if_addr;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        chk("model mem_req", 32'(bus.mem_req), 32'(m_req));
        chk("model mem_we", 32'(bus.mem_we), 32'(m_we));
        chk("model mem_addr", bus.mem_addr, m_addr);
        chk("model mem_wdata", bus.mem_wdata, m_wdata);
        chk("model if_rdata", bus.if_rdata, m_ird);
        chk("model dm_rdata", bus.dm_rdata, m_drd);
        chk("model dm_stall", 32'(bus.dm_stall), 32'((bus.dm_read | bus.dm_write) & ~m_done_d));
        chk("model if_stall", 32'(bus.if_stall), 32'(bus.if_req & ~(m_done_i && bus.if_addr == m_addr)));
    endtask

    task automatic set_in(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                          input logic [31:0] da, input logic [31:0] dwd, input logic rdy, input logic [31:0] rd);
        bus.if_req = ir; bus.if_addr = ia; bus.dm_read = dr; bus.dm_write = dw;
        bus.dm_addr = da; bus.dm_wdata = dwd; bus.mem_ready = rdy; bus.mem_rdata = rd;
    endtask

    task automatic sample();
        @(negedge clk);
        cmp_model();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b1;
    endtask

    vec_t tv[13];

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tv[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0};
        tv[1]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0};
        tv[2]  = '{1, 0, 0, 1, 0, 32'h100, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0, 0};
        tv[3]  = '{1, 0, 0, 1, 0, 32'h100, 0, 1, 32'hDEADBEEF, 1, 0, 32'h100, 0, 1, 0, 0};
        tv[4]  = '{1, 0, 0, 1, 0, 32'h100, 0, 1, 32'hDEADBEEF, 0, 0, 32'h100, 0, 0, 0, 32'hDEADBEEF};
        tv[5]  = '{1, 0, 0, 0, 0, 0, 0, 1, 0,                 0, 0, 32'h100, 0, 0, 0, 32'hDEADBEEF};
        tv[6]  = '{1, 0, 0, 0, 1, 32'h200, 32'h12345678, 0, 0, 0, 0, 32'h100, 0, 1, 0, 32'hDEADBEEF};
        for (int i = 7; i < 10; i++)
            tv[i] = '{1, 0, 0, 0, 1, 32'h200, 32'h12345678, 0, 0, 1, 1, 32'h200, 32'h12345678, 1, 0, 32'hDEADBEEF};
        tv[10] = '{1, 0, 0, 0, 1, 32'h200, 32'h12345678, 1, 0, 1, 1, 32'h200, 32'h12345678, 1, 0, 32'hDEADBEEF};
        tv[11] = '{1, 0, 0, 0, 1, 32'h200, 32'h12345678, 1, 0, 0, 1, 32'h200, 32'h12345678, 0, 0, 32'hDEADBEEF};
        tv[12] = '{1, 0, 0, 0, 0, 0, 0, 0, 0,                 0, 1, 32'h200, 32'h12345678, 0, 0, 32'hDEADBEEF};
        #1;
        for (int i = 0; i < 13; i++) begin
            rst = tv[i].rst;
            set_in(tv[i].if_req, tv[i].if_addr, tv[i].dm_read, tv[i].dm_write,
                   tv[i].dm_addr, tv[i].dm_wdata, tv[i].ready, tv[i].rdata);
            sample();
            chk($sformatf("vec%0d mem_req", i), 32'(bus.mem_req), 32'(tv[i].e_req));
            chk($sformatf("vec%0d mem_we", i), 32'(bus.mem_we), 32'(tv[i].e_we));
            chk($sformatf("vec%0d mem_addr", i), bus.mem_addr, tv[i].e_addr);
            chk($sformatf("vec%0d mem_wdata", i), bus.mem_wdata, tv[i].e_wdata);
            chk($sformatf("vec%0d dm_stall", i), 32'(bus.dm_stall), 32'(tv[i].e_dst));
            chk($sformatf("vec%0d if_stall", i), 32'(bus.if_stall), 32'(tv[i].e_ist));
            chk($sformatf("vec%0d dm_rdata", i), bus.dm_rdata, tv[i].e_drd);
            tick();
        end

        // Contention: data wins, fetch follows after DDONE.
        do_reset();
        set_in(1, 32'h400, 1, 0, 32'h100, 0, 1, 32'hAAAA0001);
        sample(); chk("cont idle if_stall", 32'(bus.if_stall), 1); chk("cont idle dm_stall", 32'(bus.dm_stall), 1);
        tick();
        sample(); chk("cont dbusy addr", bus.mem_addr, 32'h100); chk("cont dbusy if_stall", 32'(bus.if_stall), 1);
        tick();
        sample(); chk("cont ddone dm_stall", 32'(bus.dm_stall), 0); chk("cont ddone if_stall", 32'(bus.if_stall), 1);
        chk("cont dm_rdata", bus.dm_rdata, 32'hAAAA0001);
        tick();
        set_in(1, 32'h400, 0, 0, 0, 0, 1, 32'hBBBB0002);
        sample(); chk("cont idle2 mem_req", 32'(bus.mem_req), 0); chk("cont idle2 if_stall", 32'(bus.if_stall), 1);
        tick();
        sample(); chk("cont ibusy addr", bus.mem_addr, 32'h400); chk("cont ibusy we", 32'(bus.mem_we), 0);
        tick();
        sample(); chk("cont idone if_stall", 32'(bus.if_stall), 0); chk("cont if_rdata", bus.if_rdata, 32'hBBBB0002);
        tick();

        // Redirect during IBUSY.
        do_reset();
        set_in(1, 32'h400, 0, 0, 0, 0, 0, 0);
        sample(); tick();
        set_in(1, 32'h800, 0, 0, 0, 0, 1, 32'h11110400);
        sample(); chk("redir ibusy addr", bus.mem_addr, 32'h400); chk("redir ibusy req", 32'(bus.mem_req), 1);
        tick();
        set_in(1, 32'h800, 0, 0, 0, 0, 0, 0);
        sample(); chk("redir idone if_stall", 32'(bus.if_stall), 1); chk("redir old rdata", bus.if_rdata, 32'h11110400);
        tick();
        sample(); tick();
        set_in(1, 32'h800, 0, 0, 0, 0, 1, 32'h22220800);
        sample(); chk("redir new addr", bus.mem_addr, 32'h800); chk("redir new req", 32'(bus.mem_req), 1);
        tick();
        sample(); chk("redir new if_stall", 32'(bus.if_stall), 0); chk("redir new rdata", bus.if_rdata, 32'h22220800);
        tick();

        // Reset during DBUSY, then re-issue.
        do_reset();
        set_in(0, 0, 0, 1, 32'h300, 32'h55, 0, 0);
        sample(); tick();
        sample(); chk("rst dbusy req", 32'(bus.mem_req), 1);
        rst = 1'b0;
        #1;
        chk("rst mem_req", 32'(bus.mem_req), 0); chk("rst mem_we", 32'(bus.mem_we), 0);
        chk("rst mem_addr", bus.mem_addr, 0); chk("rst mem_wdata", bus.mem_wdata, 0);
        chk("rst if_rdata", bus.if_rdata, 0); chk("rst dm_rdata", bus.dm_rdata, 0);
        tick();
        rst = 1'b1;
        sample(); chk("rst idle dm_stall", 32'(bus.dm_stall), 1); chk("rst idle req", 32'(bus.mem_req), 0);
        tick();
        sample(); chk("rst reissue addr", bus.mem_addr, 32'h300); chk("rst reissue we", 32'(bus.mem_we), 1);
        tick();

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) != 0);
            bus.if_req = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) bus.if_addr = 32'($urandom_range(0, 3)) << 8;
            bus.dm_read = ($urandom_range(0, 3) == 0);
            bus.dm_write = ($urandom_range(0, 5) == 0);
            bus.dm_addr = $urandom;
            bus.dm_wdata = $urandom;
            bus.mem_ready = ($urandom_range(0, 2) != 0);
            bus.mem_rdata = $urandom;
            sample();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports are named clk and rst as elsewhere in the pipeline.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-low reset (0 = reset).
REQ-004 if_req  input  1  fetch stage requests an instruction word.
REQ-005 if_addr  input  32  fetch address.
REQ-006 if_rdata  output  32  registered fetched word.
REQ-007 if_stall  output  1  hold fetch stage and pipeline registers upstream of it.
REQ-008 dm_read  input  1  MEM stage load.
REQ-009 dm_write  input  1  MEM stage store.
REQ-010 dm_addr  input  32  MEM stage address, equal to the EX/MEM ALU result.
REQ-011 dm_wdata  input  32  store data, equal to the EX/MEM write data.
REQ-012 dm_rdata  output  32  registered load data.
REQ-013 dm_stall  output  1  hold the whole pipeline, with the EX/MEM register write-enable low.
REQ-014 mem_req  output  1  shared memory port request, registered.
REQ-015 mem_we  output  1  1 = write transaction, registered.
REQ-016 mem_addr  output  32  registered transaction address.
REQ-017 mem_wdata  output  32  registered write data.
REQ-018 mem_ready  input  1  memory completes the current transaction in this cycle.
REQ-019 mem_rdata  input  32  read data, valid when mem_ready=1.

Function
REQ-020 The FSM SHALL have the states IDLE, IBUSY, DBUSY, IDONE and DDONE.
REQ-021 In IDLE, a data request (dm_read|dm_write) SHALL go to DBUSY; otherwise if_req SHALL go to IBUSY; otherwise the FSM SHALL stay in IDLE. Data has fixed priority.
REQ-022 On the grant edge, the block SHALL latch mem_addr, mem_wdata and mem_we from the granted requester and set mem_req=1. For a fetch, mem_we=0 and mem_wdata is unchanged.
REQ-023 mem_req, mem_we, mem_addr and mem_wdata SHALL stay constant while in IBUSY or DBUSY.
REQ-024 In xBUSY, mem_ready=1 SHALL complete the transaction: mem_req goes to 0 on that edge, the FSM moves to IDONE or DDONE, and for a read mem_rdata is captured into if_rdata or dm_rdata.
REQ-025 If dm_read and dm_write are both 1, the transaction SHALL be a write.
REQ-026 xDONE SHALL last exactly one cycle and SHALL then return to IDLE unconditionally.
REQ-027 dm_stall = (dm_read|dm_write) & (state != DDONE).
REQ-028 if_stall = if_req & !(state == IDONE & if_addr == latched mem_addr).
REQ-029 If the fetch address changes during IBUSY (redirect), the old transaction SHALL still complete. Its data is discarded by the IDONE address compare, and the new address is re-arbitrated from IDLE.
REQ-030 If a requester drops its request during xBUSY, the transaction SHALL still complete, and no stall is asserted for the dropped requester.
REQ-031 The minimum latency SHALL be: request seen in IDLE at cycle 0, mem_req=1 at cycle 1, mem_ready=1 at cycle 1, DONE with stall low at cycle 2.
REQ-032 A fetch pending during a data transaction SHALL be granted in the IDLE following DDONE, provided no new data request is present.
REQ-033 mem_ready asserted while mem_req=0 SHALL be ignored.
REQ-034 Read-data registers SHALL hold their value until the next completed read of the same requester.

Reset
REQ-035 While rst=0, the block SHALL force, asynchronously, state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rdata=0 and dm_rdata=0.
REQ-036 A reset during xBUSY SHALL abandon the transaction, with mem_req dropping immediately.
REQ-037 The first grant SHALL occur no earlier than the first rising edge after rst goes to 1.

Verification
REQ-038 Load, zero-wait: dm_read=1, dm_addr=0x100, mem_ready held at 1, mem_rdata=0xDEADBEEF -> dm_stall=1 for 2 cycles, mem_req=1 in cycle 1 only, dm_rdata=0xDEADBEEF and dm_stall=0 in cycle 2.
REQ-039 Store with 3 wait states: dm_write=1, addr 0x200, data 0x12345678 -> mem_we=1 and mem_addr/mem_wdata stable for 4 cycles until mem_ready, then DDONE with dm_stall=0.
REQ-040 Contention: if_req and dm_read rise in the same cycle -> data granted first, fetch granted in the IDLE after DDONE, if_stall=1 throughout until IDONE.
REQ-041 Redirect: fetch 0x400 in IBUSY, if_addr changes to 0x800 -> 0x400 transaction completes, if_stall stays 1 in IDONE, a new transaction to 0x800 follows.
REQ-042 Reset mid-operation: rst=0 asserted during DBUSY -> mem_req=0 immediately and all outputs 0; after release, the pending request is re-issued from IDLE.
